// File: rtl/phase_sequencer.sv
// Multi-cycle phase sequencer: walks one-hot phases P0..P4 per instruction class,
// waits on memory / MDU handshakes and aborts stuck waits or illegal opcodes.
//   state | meaning
//   P0    | fetch, held until mem_ready
//   P1    | decode, class latched, illegal opcodes abort here
//   P2    | execute, MDU class held until mdu_done
//   P3    | memory, held until mem_ready
//   P4    | writeback
module phase_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int RET_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       irfunc,
  input  logic [4:0]       regimm,
  input  logic             mem_ready,
  input  logic             mdu_done,
  output logic [4:0]       p,
  output logic             stall,
  output logic             mdu_start,
  output logic             retire,
  output logic             illegal,
  output logic             timeout,
  output logic [RET_W-1:0] retired_cnt
);

  localparam logic [4:0] P0 = 5'b00001;
  localparam logic [4:0] P1 = 5'b00010;
  localparam logic [4:0] P2 = 5'b00100;
  localparam logic [4:0] P3 = 5'b01000;
  localparam logic [4:0] P4 = 5'b10000;

  localparam logic [2:0] C_ALU = 3'd0;
  localparam logic [2:0] C_BR  = 3'd1;
  localparam logic [2:0] C_JMP = 3'd2;
  localparam logic [2:0] C_MDU = 3'd3;
  localparam logic [2:0] C_LD  = 3'd4;
  localparam logic [2:0] C_ST  = 3'd5;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [2:0] cls;
  logic [2:0] dec_cls;
  logic       dec_ok;
  logic [7:0] stall_cnt;
  logic       waiting;
  logic       timeout_hit;
  logic       stall_int;
  logic [4:0] p_next;

  always_comb begin
    dec_cls = C_ALU;
    dec_ok  = 1'b1;
    case (op)
      6'h00: begin
        case (irfunc)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h10, 6'h11, 6'h12, 6'h13,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B:                 dec_cls = C_ALU;
          6'h08, 6'h09:                 dec_cls = C_JMP;
          6'h18, 6'h19, 6'h1A, 6'h1B:   dec_cls = C_MDU;
          default:                      dec_ok  = 1'b0;
        endcase
      end
      6'h01: begin
        if (regimm == 5'h00 || regimm == 5'h01) dec_cls = C_BR;
        else                                    dec_ok  = 1'b0;
      end
      6'h02, 6'h03:                      dec_cls = C_JMP;
      6'h04, 6'h05, 6'h06, 6'h07:        dec_cls = C_BR;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F:        dec_cls = C_ALU;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: dec_cls = C_LD;
      6'h28, 6'h29, 6'h2B:               dec_cls = C_ST;
      default:                           dec_ok  = 1'b0;
    endcase
  end

  always_comb begin
    waiting = 1'b0;
    if (p == P0)                     waiting = ~mem_ready;
    else if (p == P2 && cls == C_MDU) waiting = ~mdu_done;
    else if (p == P3)                waiting = ~mem_ready;
  end

  assign timeout_hit = waiting && (stall_cnt == CNT_LAST);
  assign stall_int   = waiting && !timeout_hit;

  always_comb begin
    p_next = P0;
    case (p)
      P0: p_next = mem_ready ? P1 : P0;
      P1: p_next = dec_ok ? P2 : P0;
      P2: begin
        case (cls)
          C_BR:        p_next = P0;
          C_MDU:       p_next = mdu_done ? P4 : (timeout_hit ? P0 : P2);
          C_LD, C_ST:  p_next = P3;
          default:     p_next = P4;
        endcase
      end
      P3: begin
        if (mem_ready)        p_next = (cls == C_LD) ? P4 : P0;
        else if (timeout_hit) p_next = P0;
        else                  p_next = P3;
      end
      P4:      p_next = P0;
      default: p_next = P0;
    endcase
  end

  // Pulses are gated by reset so an aborted instruction never reports anything.
  assign stall     = !reset && stall_int;
  assign timeout   = !reset && timeout_hit;
  assign illegal   = !reset && (p == P1) && !dec_ok;
  assign mdu_start = !reset && (p == P2) && (cls == C_MDU) && (stall_cnt == 8'd0);
  assign retire    = !reset && ((p == P4) ||
                                (p == P2 && cls == C_BR) ||
                                (p == P3 && cls == C_ST && mem_ready));

  always_ff @(posedge clk) begin
    if (reset) begin
      p           <= P0;
      cls         <= C_ALU;
      stall_cnt   <= 8'd0;
      retired_cnt <= '0;
    end else begin
      p         <= p_next;
      stall_cnt <= stall_int ? stall_cnt + 8'd1 : 8'd0;
      if (p == P1 && dec_ok) cls <= dec_cls;
      if (retire) retired_cnt <= retired_cnt + RET_W'(1);
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: per-cycle phase, handshake and pulse checks
// against hand-computed vectors for each instruction class and abort path.
module tb_phase_sequencer;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op;
  logic [5:0]  irfunc;
  logic [4:0]  regimm;
  logic        mem_ready;
  logic        mdu_done;
  logic [4:0]  p;
  logic        stall;
  logic        mdu_start;
  logic        retire;
  logic        illegal;
  logic        timeout;
  logic [31:0] retired_cnt;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  phase_sequencer #(.TIMEOUT(TMO), .RET_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .irfunc(irfunc), .regimm(regimm),
    .mem_ready(mem_ready), .mdu_done(mdu_done), .p(p), .stall(stall),
    .mdu_start(mdu_start), .retire(retire), .illegal(illegal),
    .timeout(timeout), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1; op = 6'h00; irfunc = 6'h00; regimm = 5'h00;
    mem_ready = 1'b0; mdu_done = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (p !== 5'b00001) begin bad++; $display("FAIL reset_p got=%b want=00001", p); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    total++; if ({mdu_start, retire, illegal, timeout} !== 4'b0000) begin
      bad++; $display("FAIL reset_pulses got=%b want=0000", {mdu_start, retire, illegal, timeout});
    end
    total++; if (retired_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", retired_cnt); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_add();
    logic [4:0] ep [4] = '{5'b00001, 5'b00010, 5'b00100, 5'b10000};
    logic       er [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    op = 6'h00; irfunc = 6'h20; mem_ready = 1'b1; mdu_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (p !== ep[i]) begin bad++; $display("FAIL add_p cyc%0d got=%b want=%b", i, p, ep[i]); end
      total++; if (retire !== er[i]) begin bad++; $display("FAIL add_retire cyc%0d got=%b want=%b", i, retire, er[i]); end
      total++; if (stall !== 1'b0 || illegal !== 1'b0) begin
        bad++; $display("FAIL add_stall_ill cyc%0d got=%b%b want=00", i, stall, illegal);
      end
      @(posedge clk); #1;
    end
    exp_cnt++;
    total++; if (p !== 5'b00001) begin bad++; $display("FAIL add_end_p got=%b want=00001", p); end
    total++; if (retired_cnt !== 32'(exp_cnt)) begin bad++; $display("FAIL add_cnt got=%0d want=%0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_lw_wait();
    logic       mr [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0] ep [8] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000,
                           5'b01000, 5'b01000, 5'b01000, 5'b10000};
    logic       es [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       er [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    op = 6'h23; irfunc = 6'h00; mdu_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      @(negedge clk);
      total++; if (p !== ep[i]) begin bad++; $display("FAIL lw_p cyc%0d got=%b want=%b", i, p, ep[i]); end
      total++; if (stall !== es[i]) begin bad++; $display("FAIL lw_stall cyc%0d got=%b want=%b", i, stall, es[i]); end
      total++; if (retire !== er[i]) begin bad++; $display("FAIL lw_retire cyc%0d got=%b want=%b", i, retire, er[i]); end
      @(posedge clk); #1;
    end
    exp_cnt++;
    total++; if (p !== 5'b00001) begin bad++; $display("FAIL lw_end_p got=%b want=00001", p); end
    total++; if (retired_cnt !== 32'(exp_cnt)) begin bad++; $display("FAIL lw_cnt got=%0d want=%0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ov [7] = '{6'h04, 6'h04, 6'h04, 6'h2B, 6'h2B, 6'h2B, 6'h2B};
    logic [4:0] ep [7] = '{5'b00001, 5'b00010, 5'b00100, 5'b00001,
                           5'b00010, 5'b00100, 5'b01000};
    logic       er [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    irfunc = 6'h00; mem_ready = 1'b1; mdu_done = 1'b0;
    for (int i = 0; i < 7; i++) begin
      op = ov[i];
      @(negedge clk);
      total++; if (p !== ep[i]) begin bad++; $display("FAIL b2b_p cyc%0d got=%b want=%b", i, p, ep[i]); end
      total++; if (retire !== er[i]) begin bad++; $display("FAIL b2b_retire cyc%0d got=%b want=%b", i, retire, er[i]); end
      @(posedge clk); #1;
    end
    exp_cnt += 2;
    total++; if (p !== 5'b00001) begin bad++; $display("FAIL b2b_end_p got=%b want=00001", p); end
    total++; if (retired_cnt !== 32'(exp_cnt)) begin bad++; $display("FAIL b2b_cnt got=%0d want=%0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_div();
    logic       md [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0] ep [9] = '{5'b00001, 5'b00010, 5'b00100, 5'b00100, 5'b00100,
                           5'b00100, 5'b00100, 5'b00100, 5'b10000};
    logic       es [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       em [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       er [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    op = 6'h00; irfunc = 6'h1A;
    for (int i = 0; i < 9; i++) begin
      mem_ready = (i == 0);
      mdu_done  = md[i];
      @(negedge clk);
      total++; if (p !== ep[i]) begin bad++; $display("FAIL div_p cyc%0d got=%b want=%b", i, p, ep[i]); end
      total++; if (stall !== es[i]) begin bad++; $display("FAIL div_stall cyc%0d got=%b want=%b", i, stall, es[i]); end
      total++; if (mdu_start !== em[i]) begin bad++; $display("FAIL div_mdu_start cyc%0d got=%b want=%b", i, mdu_start, em[i]); end
      total++; if (retire !== er[i]) begin bad++; $display("FAIL div_retire cyc%0d got=%b want=%b", i, retire, er[i]); end
      @(posedge clk); #1;
    end
    exp_cnt++;
    total++; if (p !== 5'b00001) begin bad++; $display("FAIL div_end_p got=%b want=00001", p); end
    total++; if (retired_cnt !== 32'(exp_cnt)) begin bad++; $display("FAIL div_cnt got=%0d want=%0d", retired_cnt, exp_cnt); end
  endtask

  // Zero-wait decode sweep: latency from P0 back to P0 per opcode.
  task automatic test_decode();
    logic [5:0] tv_op  [16] = '{6'h04, 6'h01, 6'h01, 6'h02, 6'h00, 6'h0F, 6'h25, 6'h28,
                                6'h00, 6'h00, 6'h00, 6'h01, 6'h00, 6'h30, 6'h20, 6'h07};
    logic [5:0] tv_fn  [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h00, 6'h00, 6'h00,
                                6'h10, 6'h19, 6'h00, 6'h00, 6'h01, 6'h00, 6'h00, 6'h00};
    logic [4:0] tv_ri  [16] = '{5'h00, 5'h00, 5'h01, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00,
                                5'h00, 5'h00, 5'h00, 5'h11, 5'h00, 5'h00, 5'h00, 5'h00};
    int         tv_lat [16] = '{3, 3, 3, 4, 4, 4, 5, 4, 4, 4, 4, 2, 2, 2, 5, 3};
    int         tv_ill [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    int cyc, ill_seen, ret_seen;
    mem_ready = 1'b1; mdu_done = 1'b1;
    for (int k = 0; k < 16; k++) begin
      op = tv_op[k]; irfunc = tv_fn[k]; regimm = tv_ri[k];
      cyc = 0; ill_seen = 0; ret_seen = 0;
      do begin
        @(negedge clk);
        if (illegal === 1'b1) ill_seen++;
        if (retire === 1'b1) ret_seen++;
        cyc++;
        @(posedge clk); #1;
      end while (p !== 5'b00001 && cyc < 20);
      if (tv_ill[k] == 0) exp_cnt++;
      total++; if (cyc != tv_lat[k]) begin bad++; $display("FAIL dec_latency op=%h fn=%h got=%0d want=%0d", op, irfunc, cyc, tv_lat[k]); end
      total++; if (ill_seen != tv_ill[k]) begin bad++; $display("FAIL dec_illegal op=%h fn=%h got=%0d want=%0d", op, irfunc, ill_seen, tv_ill[k]); end
      total++; if (ret_seen != 1 - tv_ill[k]) begin bad++; $display("FAIL dec_retire op=%h fn=%h got=%0d want=%0d", op, irfunc, ret_seen, 1 - tv_ill[k]); end
      total++; if (retired_cnt !== 32'(exp_cnt)) begin bad++; $display("FAIL dec_cnt op=%h got=%0d want=%0d", op, retired_cnt, exp_cnt); end
    end
    regimm = 5'h00; mdu_done = 1'b0;
  endtask

  task automatic test_illegal_timeout();
    op = 6'h3F; irfunc = 6'h00; mem_ready = 1'b1; mdu_done = 1'b0;
    @(negedge clk);
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL ill_p0 got=%b want=0", illegal); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (p !== 5'b00010 || illegal !== 1'b1 || retire !== 1'b0) begin
      bad++; $display("FAIL ill_p1 got p=%b ill=%b ret=%b want p=00010 ill=1 ret=0", p, illegal, retire);
    end
    @(posedge clk); #1;
    total++; if (p !== 5'b00001) begin bad++; $display("FAIL ill_back_p got=%b want=00001", p); end
    mem_ready = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      total++; if (p !== 5'b00001) begin bad++; $display("FAIL tmo_p cyc%0d got=%b want=00001", i, p); end
      total++; if (timeout !== (i == TMO - 1)) begin bad++; $display("FAIL tmo_pulse cyc%0d got=%b want=%b", i, timeout, i == TMO - 1); end
      total++; if (stall !== (i != TMO - 1)) begin bad++; $display("FAIL tmo_stall cyc%0d got=%b want=%b", i, stall, i != TMO - 1); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++; if (timeout !== 1'b0 || stall !== 1'b1 || retire !== 1'b0) begin
      bad++; $display("FAIL tmo_restart got tmo=%b stall=%b ret=%b want 0 1 0", timeout, stall, retire);
    end
    @(posedge clk); #1;
    total++; if (retired_cnt !== 32'(exp_cnt)) begin bad++; $display("FAIL tmo_cnt got=%0d want=%0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [4:0] ep [4] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000};
    op = 6'h21; irfunc = 6'h00; mdu_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 0);
      @(negedge clk);
      total++; if (p !== ep[i]) begin bad++; $display("FAIL lh_p cyc%0d got=%b want=%b", i, p, ep[i]); end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    total++; if (p !== 5'b01000 || {stall, retire, timeout} !== 3'b000) begin
      bad++; $display("FAIL rst_mid_during got p=%b st/ret/tmo=%b want 01000 000", p, {stall, retire, timeout});
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1;
    exp_cnt = 0;
    total++; if (p !== 5'b00001) begin bad++; $display("FAIL rst_mid_p got=%b want=00001", p); end
    total++; if (retired_cnt !== 32'(exp_cnt)) begin bad++; $display("FAIL rst_mid_cnt got=%0d want=0", retired_cnt); end
    @(negedge clk);
    total++; if ({stall, mdu_start, retire, illegal, timeout} !== 5'b00000) begin
      bad++; $display("FAIL rst_mid_pulses got=%b want=00000", {stall, mdu_start, retire, illegal, timeout});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_back_to_back();
    test_div();
    test_decode();
    test_illegal_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
